// File: rtl/vote_result_evaluator_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vote_result_evaluator_pkg
// Description : Shared constants for the vote result evaluator: FSM state
//               encoding, candidate index width and the default tally width
//               (kept identical to the vote logger's tally width).
// Revision    : 1.0 - initial release
// ============================================================================
package vote_result_evaluator_pkg;

    // Tally width used by the vote logger; the evaluator defaults to it.
    localparam int CNT_W_DEFAULT = 8;

    // Four candidates in this release -> 2-bit candidate index.
    localparam int CAND_IDX_W = 2;

    // Evaluator FSM encoding.
    localparam int                 STATE_W = 2;
    localparam logic [STATE_W-1:0] ST_IDLE = 2'd0;
    localparam logic [STATE_W-1:0] ST_SCAN = 2'd1;
    localparam logic [STATE_W-1:0] ST_DONE = 2'd2;
    localparam logic [STATE_W-1:0] ST_SHOW = 2'd3;

endpackage : vote_result_evaluator_pkg
`default_nettype wire

// File: rtl/vote_result_evaluator_display_rotator.sv
`default_nettype none
// ============================================================================
// Module      : display_rotator
// Description : Steps the displayed candidate index. Each index is held for
//               DISP_CYCLES clocks while enabled, then advances, wrapping
//               from the last candidate back to 0.
//   clock     in   system clock
//   reset     in   synchronous active-low reset
//   enable    in   count while high (evaluator in SHOW)
//   restart   in   force counter and index to 0 at the next edge
//   disp_idx  out  registered index of the candidate being displayed
//   advance   out  high in the cycle whose edge moves disp_idx forward
// Revision    : 1.0 - initial release
// ============================================================================
module display_rotator
    import vote_result_evaluator_pkg::*;
#(
    parameter int DISP_CYCLES = 100
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  restart,
    output logic [CAND_IDX_W-1:0] disp_idx,
    output logic                  advance
);

    // A single-cycle dwell still needs a 1-bit counter to keep widths legal.
    localparam int                DCNT_W = (DISP_CYCLES > 1) ? $clog2(DISP_CYCLES) : 1;
    localparam logic [DCNT_W-1:0] C_LAST = DCNT_W'(DISP_CYCLES - 1);

    logic [DCNT_W-1:0]     r_count;
    logic [CAND_IDX_W-1:0] r_disp_idx;

    // Exported so the owner of the display value can load the next tally on
    // the same edge the index moves, keeping value and index aligned.
    assign advance  = enable && !restart && (r_count == C_LAST);
    assign disp_idx = r_disp_idx;

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_count    <= '0;
            r_disp_idx <= '0;
        end else if (restart) begin
            r_count    <= '0;
            r_disp_idx <= '0;
        end else if (enable) begin
            if (r_count == C_LAST) begin
                r_count    <= '0;
                r_disp_idx <= r_disp_idx + CAND_IDX_W'(1);
            end else begin
                r_count <= r_count + DCNT_W'(1);
            end
        end
    end

endmodule : display_rotator
`default_nettype wire

// File: rtl/vote_result_evaluator.sv
`default_nettype none
// ============================================================================
// Module      : vote_result_evaluator
// Description : Snapshots four candidate tallies on start, scans them one per
//               cycle to find winner / tie / no-votes / total, then rotates
//               the snapshot tallies onto a display output.
//   clock, reset           clock and synchronous active-low reset
//   start, clear           evaluation request / return to idle
//   cand1..4_votes         live tallies from the vote logger
//   busy, done             scan in progress / one-cycle result strobe
//   result_valid           results held valid from done to clear/start
//   winner, winner_votes   leading candidate index and its tally
//   tie, no_votes          shared nonzero maximum / all tallies zero
//   total_votes            sum of all four tallies
//   disp_idx, disp_value   rotating display of the snapshot tallies
// Revision    : 1.0 - initial release
// ============================================================================
module vote_result_evaluator
    import vote_result_evaluator_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEFAULT,
    parameter int NUM_CAND    = 4,
    parameter int DISP_CYCLES = 100
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  clear,
    input  logic [CNT_W-1:0]      cand1_votes,
    input  logic [CNT_W-1:0]      cand2_votes,
    input  logic [CNT_W-1:0]      cand3_votes,
    input  logic [CNT_W-1:0]      cand4_votes,
    output logic                  busy,
    output logic                  done,
    output logic                  result_valid,
    output logic [CAND_IDX_W-1:0] winner,
    output logic [CNT_W-1:0]      winner_votes,
    output logic                  tie,
    output logic                  no_votes,
    output logic [CNT_W+1:0]      total_votes,
    output logic [CAND_IDX_W-1:0] disp_idx,
    output logic [CNT_W-1:0]      disp_value
);

    localparam logic [CAND_IDX_W-1:0] C_LAST_IDX = CAND_IDX_W'(NUM_CAND - 1);

    logic [STATE_W-1:0]    r_state;
    logic [CNT_W-1:0]      r_snap [NUM_CAND];
    logic [CAND_IDX_W-1:0] r_idx;
    logic [CNT_W-1:0]      r_max;
    logic [CNT_W+1:0]      r_sum;
    logic                  r_run_tie;
    logic [CAND_IDX_W-1:0] r_run_winner;

    logic                  r_busy;
    logic                  r_done;
    logic                  r_result_valid;
    logic [CAND_IDX_W-1:0] r_winner;
    logic [CNT_W-1:0]      r_winner_votes;
    logic                  r_tie;
    logic                  r_no_votes;
    logic [CNT_W+1:0]      r_total_votes;
    logic [CNT_W-1:0]      r_disp_value;

    logic [CNT_W-1:0]      w_cur;
    logic                  w_gt;
    logic                  w_eq;
    logic [CNT_W-1:0]      w_next_max;
    logic [CAND_IDX_W-1:0] w_next_winner;
    logic                  w_next_tie;
    logic [CNT_W+1:0]      w_next_sum;
    logic                  w_rot_enable;
    logic                  w_rot_restart;
    logic                  w_rot_advance;
    logic [CAND_IDX_W-1:0] w_disp_next_idx;

    assign busy         = r_busy;
    assign done         = r_done;
    assign result_valid = r_result_valid;
    assign winner       = r_winner;
    assign winner_votes = r_winner_votes;
    assign tie          = r_tie;
    assign no_votes     = r_no_votes;
    assign total_votes  = r_total_votes;
    assign disp_value   = r_disp_value;

    // Comparator / accumulator for the candidate currently being scanned.
    // Only a strictly greater tally takes the lead, so the lowest index wins
    // among equal maxima; a zero maximum never counts as a tie.
    always_comb begin
        w_cur         = r_snap[r_idx];
        w_gt          = (w_cur > r_max);
        w_eq          = (w_cur == r_max) && (r_max != '0);
        w_next_max    = r_max;
        w_next_winner = r_run_winner;
        w_next_tie    = r_run_tie;
        if (w_gt) begin
            w_next_max    = w_cur;
            w_next_winner = r_idx;
            w_next_tie    = 1'b0;
        end else if (w_eq) begin
            w_next_tie = 1'b1;
        end
        w_next_sum = r_sum + {2'b00, w_cur};
    end

    // The rotator is held at index 0 everywhere except SHOW, and is also
    // forced back on the very edge a clear or restart is taken, so disp_idx
    // reads 0 from that edge onward.
    assign w_rot_enable    = (r_state == ST_SHOW);
    assign w_rot_restart   = clear || start || (r_state != ST_SHOW);
    assign w_disp_next_idx = disp_idx + CAND_IDX_W'(1);

    display_rotator #(
        .DISP_CYCLES (DISP_CYCLES)
    ) u_display_rotator (
        .clock    (clock),
        .reset    (reset),
        .enable   (w_rot_enable),
        .restart  (w_rot_restart),
        .disp_idx (disp_idx),
        .advance  (w_rot_advance)
    );

    always_ff @(posedge clock) begin
        if (!reset || clear) begin
            r_state        <= ST_IDLE;
            r_idx          <= '0;
            r_max          <= '0;
            r_sum          <= '0;
            r_run_tie      <= 1'b0;
            r_run_winner   <= '0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_result_valid <= 1'b0;
            r_winner       <= '0;
            r_winner_votes <= '0;
            r_tie          <= 1'b0;
            r_no_votes     <= 1'b0;
            r_total_votes  <= '0;
            r_disp_value   <= '0;
            // Only reset wipes the snapshot; clear leaves it (it is not
            // observable until the next start overwrites it anyway).
            if (!reset) begin
                for (int i = 0; i < NUM_CAND; i++) begin
                    r_snap[i] <= '0;
                end
            end
        end else if (start && (r_state != ST_SCAN)) begin
            // Restart from IDLE, DONE or SHOW; start is ignored mid-scan.
            r_snap[0]      <= cand1_votes;
            r_snap[1]      <= cand2_votes;
            r_snap[2]      <= cand3_votes;
            r_snap[3]      <= cand4_votes;
            r_idx          <= '0;
            r_max          <= '0;
            r_sum          <= '0;
            r_run_tie      <= 1'b0;
            r_run_winner   <= '0;
            r_busy         <= 1'b1;
            r_done         <= 1'b0;
            r_result_valid <= 1'b0;
            r_disp_value   <= '0;
            r_state        <= ST_SCAN;
        end else begin
            case (r_state)
                ST_SCAN: begin
                    r_max        <= w_next_max;
                    r_run_winner <= w_next_winner;
                    r_run_tie    <= w_next_tie;
                    r_sum        <= w_next_sum;
                    if (r_idx == C_LAST_IDX) begin
                        r_winner       <= w_next_winner;
                        r_winner_votes <= w_next_max;
                        r_tie          <= w_next_tie;
                        r_total_votes  <= w_next_sum;
                        r_no_votes     <= (w_next_sum == '0);
                        r_busy         <= 1'b0;
                        r_done         <= 1'b1;
                        r_result_valid <= 1'b1;
                        r_state        <= ST_DONE;
                    end else begin
                        r_idx <= r_idx + CAND_IDX_W'(1);
                    end
                end
                ST_DONE: begin
                    r_done       <= 1'b0;
                    r_disp_value <= r_snap[0];
                    r_state      <= ST_SHOW;
                end
                ST_SHOW: begin
                    if (w_rot_advance) begin
                        r_disp_value <= r_snap[w_disp_next_idx];
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule : vote_result_evaluator
`default_nettype wire

// File: doc/vote_result_evaluator.md
Name: vote_result_evaluator

Overview:
- Downstream of the voting machine's vote logger; consumes the four 8-bit candidate tallies when the election is closed.
- On a start pulse it snapshots the tallies and scans them one candidate per cycle. It computes the winner, the winner's count, a tie flag, a no-votes flag and the total.
- After the scan it rotates the snapshot tallies onto a display output, one candidate at a time.

Parameters:
- CNT_W, 8, width of each candidate tally.
- NUM_CAND, 4, number of candidates; fixed at 4 in this release; index width 2.
- DISP_CYCLES, 100, clock cycles each candidate is shown in SHOW state; minimum 1.

Ports:
- clock  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-low reset (reset==0 at a rising edge clears all state).
- start  in  1  request evaluation; sampled each cycle, level treated as a request.
- clear  in  1  return to IDLE and zero all outputs; lower priority than reset, higher than start.
- cand1_votes..cand4_votes  in  CNT_W each  live tallies from the vote logger.
- busy  out  1  high in SCAN.
- done  out  1  one-cycle pulse when results become valid.
- result_valid  out  1  high from done until clear, reset or next start.
- winner  out  2  winning candidate index (0 = candidate 1).
- winner_votes  out  CNT_W  winner's tally.
- tie  out  1  at least two candidates share the maximum, and the maximum is nonzero.
- no_votes  out  1  all four tallies zero.
- total_votes  out  CNT_W+2  sum of all tallies; no overflow possible.
- disp_idx  out  2  candidate index being displayed.
- disp_value  out  CNT_W  snapshot tally of disp_idx.

Behaviour:
- Reset:
  - All outputs are 0 and the state is IDLE.
  - The snapshot registers, scan index, display counter and running max/sum are all 0.
- States are IDLE, SCAN, DONE and SHOW.
- IDLE:
  - If start=1 at edge E: snapshot all four inputs, zero running max/sum/tie/winner, idx=0, go to SCAN.
  - result_valid is deasserted at the same edge.
- SCAN:
  - One candidate per edge, at E+1..E+4, for idx=0..3.
  - If snap[idx] > max: max=snap[idx], winner=idx, tie=0.
  - Else if snap[idx] == max and max != 0: tie=1.
  - sum += snap[idx].
  - start is ignored in SCAN. Inputs changing during SCAN have no effect.
- At edge E+4 (the last candidate):
  - Register the final winner, winner_votes, tie, total_votes and no_votes=(final sum==0).
  - Set done=1 and result_valid=1, go to DONE.
  - Latency is start edge to done high = 4 cycles.
- DONE:
  - Lasts one cycle.
  - done drops at the next edge; the state goes to SHOW with disp_idx=0 and the display counter at 0.
- SHOW:
  - disp_value = snap[disp_idx].
  - The counter increments each cycle. When it reaches DISP_CYCLES-1 it resets to 0 and disp_idx advances, wrapping 3 to 0.
  - start in DONE or SHOW restarts exactly as in IDLE: new snapshot, result_valid=0, disp_idx=0, disp_value=0.
- Tie resolution:
  - Only strictly greater replaces the leader, so the winner is the lowest index among tied maxima.
  - When all tallies are zero: winner=0, winner_votes=0, tie=0, no_votes=1.
- clear, in any state: next edge gives IDLE, with every output and the display counter set to 0.
- Reset mid-SCAN aborts the scan; done is never emitted for the aborted run.
- disp_value and disp_idx are 0 outside SHOW.
- Outputs:
  - All outputs are registered; there are no combinational input-to-output paths.
  - Saturated 255 tallies are handled; total max is 1020, which fits in 10 bits.

Decomposition:
- Shared package:
  - State encoding localparams: ST_IDLE, ST_SCAN, ST_DONE, ST_SHOW.
  - CAND_IDX_W=2.
  - The CNT_W default, shared with the vote logger.
- Sub-module display_rotator: owns the DISP_CYCLES counter and disp_idx wrap.
  - Inputs: enable, restart.
  - Output: disp_idx.
- The top block holds the snapshot, the FSM and the comparator/accumulator.

Test Plan:
- Tallies 3,7,2,5; start pulse at edge E:
  - Required: busy for 4 cycles, then done at E+4 for exactly 1 cycle.
  - Results: winner=1, winner_votes=7, tie=0, total_votes=17, no_votes=0.
- Tie case, tallies 6,2,6,1:
  - winner=0, winner_votes=6, tie=1, total=15.
  - Also tallies 255,255,255,255: winner=0, tie=1, total_votes=1020.
- Tallies 0,0,0,0: winner=0, winner_votes=0, tie=0, no_votes=1, total=0.
- Input changes and restarts, tallies 1,2,3,4, start:
  - Change cand4 to 9 at E+2: results still winner=3, winner_votes=4.
  - start pulsed at E+2 is ignored.
  - start in SHOW re-snapshots: new result with winner=3, winner_votes=9.
- SHOW rotation with DISP_CYCLES=4, tallies 3,7,2,5:
  - disp_value sequence is 3,3,3,3,7,7,7,7,2,2,2,2,5,5,5,5,3...
  - disp_idx wraps from 3 to 0.
- reset=0 at E+2 during SCAN: all outputs 0 the next cycle and no done pulse.
  - clear in SHOW: IDLE, result_valid=0, disp_value=0.
